// File: rtl/btn_reset_pkg.sv
// Shared definitions for the button-conditioning and bootloader reset block.
// Contents:
//   state_e            reset-sequencer FSM encoding (POR, RUN, HOLD)
//   *_DEF              default timing and board constants for a 48 MHz clock
//   cnt_width()        width of a counter that must hold the values 0..n
package btn_reset_pkg;

    typedef enum logic [1:0] {
        ST_POR  = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_e;

    localparam int              N_BTN_DEF      = 7;
    localparam logic [6:0]      ACTIVE_LOW_DEF = 7'b0000001;
    localparam int              RST_BTN_DEF    = 0;
    localparam int              DEBOUNCE_DEF   = 480000;    // 10 ms
    localparam int              POR_DEF        = 65536;
    localparam int              LONG_DEF       = 96000000;  // 2 s

    function automatic int cnt_width(input int n);
        return $clog2(n + 1);
    endfunction

endpackage

// File: rtl/btn_reset_ctrl_if.sv
// Button/reset bundle between the board-level logic and the conditioning block.
// Signals:
//   btn         raw asynchronous button pins
//   btn_db      debounced level, 1 = pressed
//   btn_rise    one-cycle pulse on debounced press
//   btn_fall    one-cycle pulse on debounced release
//   boot_reset  active-high reset for the bootloader core
//   long_press  one-cycle pulse when the reset button is held long enough
// Modports: master drives the pins and observes the results; slave is the
// conditioning block itself.
interface btn_reset_ctrl_if
    import btn_reset_pkg::*;
#(
    parameter int N_BTN = N_BTN_DEF
);
    logic [N_BTN-1:0] btn;
    logic [N_BTN-1:0] btn_db;
    logic [N_BTN-1:0] btn_rise;
    logic [N_BTN-1:0] btn_fall;
    logic             boot_reset;
    logic             long_press;

    modport master (
        output btn,
        input  btn_db, btn_rise, btn_fall, boot_reset, long_press
    );

    modport slave (
        input  btn,
        output btn_db, btn_rise, btn_fall, boot_reset, long_press
    );
endinterface

// File: rtl/btn_debounce.sv
// Single-button synchroniser and debouncer.
// Ports:
//   clk_i   system clock
//   srst_i  synchronous active-high reset
//   btn_i   raw asynchronous pin
//   db_o    debounced level, 1 = pressed
//   rise_o  one-cycle pulse in the cycle db_o goes high
//   fall_o  one-cycle pulse in the cycle db_o goes low
// A level change is accepted only after it has been seen on the synchronised
// input for DEBOUNCE_CYCLES consecutive cycles; any agreeing cycle restarts it.
module btn_debounce
    import btn_reset_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter bit ACTIVE_LOW      = 1'b0
)(
    input  logic clk_i,
    input  logic srst_i,
    input  logic btn_i,
    output logic db_o,
    output logic rise_o,
    output logic fall_o
);
    localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);

    logic             sync1_q, sync2_q;
    logic             db_q, rise_q, fall_q;
    logic [CNT_W-1:0] cnt_q;
    logic             pressed;
    logic             differs;

    assign pressed = sync2_q ^ ACTIVE_LOW;
    assign differs = (pressed != db_q);

    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            // Synchroniser starts at the idle pin level so no false press follows reset.
            sync1_q <= ACTIVE_LOW;
            sync2_q <= ACTIVE_LOW;
            db_q    <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            sync1_q <= btn_i;
            sync2_q <= sync1_q;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            if (!differs) begin
                cnt_q <= '0;
            end else if (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
                cnt_q  <= '0;
                db_q   <= pressed;
                rise_q <= pressed;
                fall_q <= ~pressed;
            end else begin
                cnt_q <= cnt_q + CNT_W'(1);
            end
        end
    end

    assign db_o   = db_q;
    assign rise_o = rise_q;
    assign fall_o = fall_q;
endmodule

// File: rtl/btn_reset_ctrl.sv
// Button conditioning and bootloader reset sequencer.
// Ports:
//   clk_48mhz  system clock
//   reset      synchronous active-high reset (e.g. inverted PLL lock)
//   bus_if     button/reset bundle (slave side): raw pins in, debounced
//              levels, edge pulses, boot_reset and long_press out
// Every button gets its own debouncer. The RST_BTN button also drives a
// three-state sequencer: POR stretches boot_reset, RUN releases it, HOLD keeps
// it asserted while the button is down and flags a long press.
module btn_reset_ctrl
    import btn_reset_pkg::*;
#(
    parameter int               N_BTN           = N_BTN_DEF,
    parameter logic [N_BTN-1:0] ACTIVE_LOW      = ACTIVE_LOW_DEF,
    parameter int               RST_BTN         = RST_BTN_DEF,
    parameter int               DEBOUNCE_CYCLES = DEBOUNCE_DEF,
    parameter int               POR_CYCLES      = POR_DEF,
    parameter int               LONG_CYCLES     = LONG_DEF
)(
    input  logic              clk_48mhz,
    input  logic              reset,
    btn_reset_ctrl_if.slave   bus_if
);
    localparam int POR_W  = cnt_width(POR_CYCLES);
    localparam int HOLD_W = cnt_width(LONG_CYCLES);

    logic [N_BTN-1:0] db_w, rise_w, fall_w;

    for (genvar gi = 0; gi < N_BTN; gi++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .ACTIVE_LOW      (ACTIVE_LOW[gi])
        ) u_db (
            .clk_i  (clk_48mhz),
            .srst_i (reset),
            .btn_i  (bus_if.btn[gi]),
            .db_o   (db_w[gi]),
            .rise_o (rise_w[gi]),
            .fall_o (fall_w[gi])
        );
    end

    state_e            state_q, state_d;
    logic [POR_W-1:0]  por_cnt_q, por_cnt_d;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
    logic              boot_reset_q;
    logic              long_press_q, long_press_d;

    always_comb begin
        state_d      = state_q;
        por_cnt_d    = por_cnt_q;
        hold_cnt_d   = hold_cnt_q;
        long_press_d = 1'b0;
        case (state_q)
            ST_POR: begin
                if (por_cnt_q == POR_W'(POR_CYCLES - 1)) begin
                    por_cnt_d  = '0;
                    hold_cnt_d = '0;
                    // A button still held when the stretch ends goes straight to HOLD.
                    state_d    = db_w[RST_BTN] ? ST_HOLD : ST_RUN;
                end else begin
                    por_cnt_d = por_cnt_q + POR_W'(1);
                end
            end
            ST_RUN: begin
                if (rise_w[RST_BTN]) begin
                    state_d    = ST_HOLD;
                    hold_cnt_d = '0;
                end
            end
            ST_HOLD: begin
                if (fall_w[RST_BTN]) begin
                    state_d    = ST_POR;
                    por_cnt_d  = '0;
                    hold_cnt_d = '0;
                end else if (hold_cnt_q != HOLD_W'(LONG_CYCLES)) begin
                    // Saturating count; the pulse fires only on the step into LONG_CYCLES-1.
                    hold_cnt_d = hold_cnt_q + HOLD_W'(1);
                    if (hold_cnt_d == HOLD_W'(LONG_CYCLES - 1)) begin
                        long_press_d = 1'b1;
                    end
                end
            end
            default: begin
                state_d    = ST_POR;
                por_cnt_d  = '0;
                hold_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk_48mhz) begin
        if (reset) begin
            state_q      <= ST_POR;
            por_cnt_q    <= '0;
            hold_cnt_q   <= '0;
            boot_reset_q <= 1'b1;
            long_press_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            por_cnt_q    <= por_cnt_d;
            hold_cnt_q   <= hold_cnt_d;
            // Registered from the next state so boot_reset tracks the state exactly.
            boot_reset_q <= (state_d != ST_RUN);
            long_press_q <= long_press_d;
        end
    end

    assign bus_if.btn_db     = db_w;
    assign bus_if.btn_rise   = rise_w;
    assign bus_if.btn_fall   = fall_w;
    assign bus_if.boot_reset = boot_reset_q;
    assign bus_if.long_press = long_press_q;
endmodule

// File: tb/tb_btn_reset_ctrl.sv
// Directed bench for btn_reset_ctrl with short timing constants
// (debounce 16, POR stretch 32, long press 100). Outputs are sampled 1 ns
// after each rising edge; inputs change at the same point.
module tb_btn_reset_ctrl;
    logic clk = 1'b0;
    logic reset;
    int   checks = 0;
    int   errors = 0;

    always #5 clk = ~clk;

    btn_reset_ctrl_if #(.N_BTN(7)) bus_if ();

    btn_reset_ctrl #(
        .N_BTN           (7),
        .ACTIVE_LOW      (7'b0000001),
        .RST_BTN         (0),
        .DEBOUNCE_CYCLES (16),
        .POR_CYCLES      (32),
        .LONG_CYCLES     (100)
    ) dut (
        .clk_48mhz (clk),
        .reset     (reset),
        .bus_if    (bus_if)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic check_reset_outputs(input string phase);
        check({phase, "_boot_reset"}, 32'(bus_if.boot_reset), 32'd1);
        check({phase, "_btn_db"},     32'(bus_if.btn_db),     32'd0);
        check({phase, "_btn_rise"},   32'(bus_if.btn_rise),   32'd0);
        check({phase, "_btn_fall"},   32'(bus_if.btn_fall),   32'd0);
        check({phase, "_long_press"}, 32'(bus_if.long_press), 32'd0);
    endtask

    initial begin
        int         k;
        int         hi;
        int         lo;
        int         lp;
        logic [6:0] acc;

        // 1. Reset, then POR stretch of 32 cycles with all buttons idle.
        reset      = 1'b1;
        bus_if.btn = 7'h01;
        for (int i = 0; i < 5; i++) tick();
        check_reset_outputs("t1_reset");
        $display("t1: reset held 5 cycles, outputs at reset values");
        reset = 1'b0;
        hi  = 0;
        acc = '0;
        while (bus_if.boot_reset && hi < 200) begin
            hi++;
            acc = acc | bus_if.btn_rise | bus_if.btn_fall | bus_if.btn_db;
            tick();
        end
        check("t1_por_len", 32'(hi), 32'd32);
        check("t1_no_activity", 32'(acc), 32'd0);
        check("t1_no_long", 32'(bus_if.long_press), 32'd0);
        $display("t1: boot_reset high for %0d cycles after reset release", hi);

        // 2. 10-cycle glitch on btn[3] must be filtered out.
        bus_if.btn = 7'h09;
        for (int i = 0; i < 10; i++) tick();
        bus_if.btn = 7'h01;
        acc = '0;
        for (int i = 0; i < 30; i++) begin
            tick();
            acc = acc | bus_if.btn_db | bus_if.btn_rise | bus_if.btn_fall;
        end
        check("t2_glitch_hidden", 32'(acc), 32'd0);
        check("t2_boot_reset_low", 32'(bus_if.boot_reset), 32'd0);
        $display("t2: 10-cycle glitch on btn[3], activity mask %0h", acc);

        // 3. Held press on btn[3]: rise after 18 cycles, fall 18 cycles after release.
        bus_if.btn = 7'h09;
        k = 0;
        do begin tick(); k++; end while (!bus_if.btn_rise[3] && k < 60);
        check("t3_rise_latency", 32'(k), 32'd18);
        check("t3_rise_bits", 32'(bus_if.btn_rise), 32'h08);
        check("t3_db_pressed", 32'(bus_if.btn_db), 32'h08);
        tick();
        check("t3_rise_single", 32'(bus_if.btn_rise), 32'd0);
        $display("t3: btn[3] press accepted after %0d cycles", k);
        bus_if.btn = 7'h01;
        k = 0;
        do begin tick(); k++; end while (!bus_if.btn_fall[3] && k < 60);
        check("t3_fall_latency", 32'(k), 32'd18);
        check("t3_fall_bits", 32'(bus_if.btn_fall), 32'h08);
        check("t3_db_released", 32'(bus_if.btn_db), 32'd0);
        $display("t3: btn[3] release accepted after %0d cycles", k);

        // 4. Reset button held 150 cycles in RUN: HOLD, long press, re-stretch.
        bus_if.btn = 7'h00;
        k = 0;
        do begin tick(); k++; end while (!bus_if.btn_rise[0] && k < 60);
        check("t4_rise_latency", 32'(k), 32'd18);
        check("t4_boot_low_at_rise", 32'(bus_if.boot_reset), 32'd0);
        tick();
        check("t4_boot_high_next", 32'(bus_if.boot_reset), 32'd1);
        $display("t4: btn[0] press after %0d cycles, boot_reset now %0d", k, bus_if.boot_reset);
        k = 0;
        do begin tick(); k++; end while (!bus_if.long_press && k < 200);
        check("t4_long_latency", 32'(k), 32'd99);
        lp = 0;
        for (int i = 0; i < 32; i++) begin
            tick();
            if (bus_if.long_press) lp++;
        end
        check("t4_long_single", 32'(lp), 32'd0);
        $display("t4: long_press %0d cycles after HOLD entry, extra pulses %0d", k + 1, lp);
        bus_if.btn = 7'h01;
        k = 0;
        do begin tick(); k++; end while (!bus_if.btn_fall[0] && k < 60);
        check("t4_fall_latency", 32'(k), 32'd18);
        check("t4_boot_high_at_fall", 32'(bus_if.boot_reset), 32'd1);
        tick();
        hi = 0;
        while (bus_if.boot_reset && hi < 200) begin
            hi++;
            tick();
        end
        check("t4_restretch_len", 32'(hi), 32'd32);
        $display("t4: boot_reset held %0d cycles after btn_fall[0]", hi);

        // 5. btn[1] and btn[5] change on the same cycle.
        bus_if.btn = 7'h23;
        k = 0;
        do begin tick(); k++; end while (bus_if.btn_rise == 7'h00 && k < 60);
        check("t5_rise_latency", 32'(k), 32'd18);
        check("t5_rise_bits", 32'(bus_if.btn_rise), 32'h22);
        check("t5_db_bits", 32'(bus_if.btn_db), 32'h22);
        $display("t5: simultaneous press, btn_rise=%0h", bus_if.btn_rise);
        bus_if.btn = 7'h01;
        k = 0;
        do begin tick(); k++; end while (bus_if.btn_fall == 7'h00 && k < 60);
        check("t5_fall_latency", 32'(k), 32'd18);
        check("t5_fall_bits", 32'(bus_if.btn_fall), 32'h22);
        $display("t5: simultaneous release, btn_fall=%0h", bus_if.btn_fall);

        // 6. Reset while in HOLD with btn[0] pressed; POR must expire into HOLD.
        bus_if.btn = 7'h00;
        k = 0;
        do begin tick(); k++; end while (!bus_if.btn_rise[0] && k < 60);
        for (int i = 0; i < 6; i++) tick();
        check("t6_in_hold", 32'(bus_if.boot_reset), 32'd1);
        reset = 1'b1;
        tick();
        check_reset_outputs("t6_reset");
        tick();
        tick();
        reset = 1'b0;
        $display("t6: reset applied in HOLD with btn[0] pressed");
        k  = 0;
        lo = 0;
        do begin
            tick();
            k++;
            if (!bus_if.boot_reset) lo++;
        end while (!bus_if.long_press && k < 300);
        check("t6_long_latency", 32'(k), 32'd131);
        check("t6_boot_never_low", 32'(lo), 32'd0);
        check("t6_db_pressed", 32'(bus_if.btn_db), 32'h01);
        $display("t6: long_press %0d cycles after reset release, boot_reset low cycles %0d", k, lo);

        bus_if.btn = 7'h01;
        for (int i = 0; i < 4; i++) tick();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
